// File: rtl/pulse_sequencer.sv
// Pulse-train sequencer: P1, delay, then a CPMG train of P2 echoes, with receiver
// blanking and a period sync. Pulse parameters are shadowed at each period boundary.
module pulse_sequencer #(
  parameter int unsigned DEF_PER = 2000,
  parameter int unsigned DEF_P1  = 30,
  parameter int unsigned DEF_DEL = 200,
  parameter int unsigned DEF_P2  = 60,
  parameter int unsigned DEF_CP  = 1,
  parameter int unsigned DEF_BL  = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] per,
  input  logic [15:0] p1wid,
  input  logic [15:0] del,
  input  logic [15:0] p2wid,
  input  logic [7:0]  cp,
  input  logic [7:0]  p_bl,
  input  logic        bl,
  output logic        pulse,
  output logic        block_out,
  output logic        sync,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_P1, S_D1, S_P2, S_GAP, S_TAIL} state_e;
  typedef struct packed {
    state_e     st;
    logic [7:0] ec;
  } step_t;

  state_e      state_q, state_d;
  logic [31:0] pcnt_q, pcnt_d;
  logic [16:0] seg_q, seg_d;
  logic [7:0]  ecnt_q, ecnt_d;
  logic [31:0] per_q, per_d;
  logic [15:0] p1_q, p1_d, del_q, del_d, p2_q, p2_d;
  logic [7:0]  cp_q, cp_d, pbl_q, pbl_d, tail_q, tail_d;
  logic        bl_q, bl_d;
  logic        pulse_d, block_d, sync_d, busy_d;
  logic [31:0] per_eff_s;
  logic        boundary_s;
  logic [16:0] len_s;
  logic        seg_end_s;
  step_t       nxt_s;

  // Entering P2 (echo ec); zero-width P2s and zero gaps collapse in the same cycle.
  function automatic step_t enter_p2(input logic [15:0] d, input logic [15:0] w2,
                                     input logic [7:0] c, input logic [7:0] ec);
    step_t      r;
    logic [8:0] ec1;
    ec1 = {1'b0, ec} + 9'd1;
    if (w2 != 16'd0) begin
      r.st = S_P2;
      r.ec = ec;
    end else if (d != 16'd0) begin
      r.st = (ec1 < {1'b0, c}) ? S_GAP : S_TAIL;
      r.ec = ec1[7:0];
    end else begin
      r.st = S_TAIL;
      r.ec = c;
    end
    return r;
  endfunction

  function automatic step_t enter_d1(input logic [15:0] d, input logic [15:0] w2,
                                     input logic [7:0] c);
    step_t r;
    if (d != 16'd0) begin
      r.st = S_D1;
      r.ec = 8'd0;
    end else begin
      r = enter_p2(d, w2, c, 8'd0);
    end
    return r;
  endfunction

  function automatic step_t after_p2(input logic [15:0] d, input logic [7:0] c,
                                     input logic [7:0] ec);
    step_t      r;
    logic [8:0] ec1;
    ec1  = {1'b0, ec} + 9'd1;
    r.ec = ec1[7:0];
    if (ec1 < {1'b0, c}) begin
      r.st = (d != 16'd0) ? S_GAP : S_P2;
    end else begin
      r.st = S_TAIL;
    end
    return r;
  endfunction

  assign per_eff_s  = (per_q < 32'd2) ? 32'd2 : per_q;
  assign boundary_s = (state_q == S_IDLE) || (pcnt_q >= per_eff_s - 32'd1);

  // Length of the current segment; the gap is twice the delay, hence 17 bits.
  always_comb begin
    case (state_q)
      S_P1:    len_s = {1'b0, p1_q};
      S_D1:    len_s = {1'b0, del_q};
      S_P2:    len_s = {1'b0, p2_q};
      S_GAP:   len_s = {del_q, 1'b0};
      default: len_s = 17'h1FFFF;
    endcase
    seg_end_s = (state_q != S_IDLE) && (state_q != S_TAIL) && (seg_q + 17'd1 >= len_s);
  end

  // Next-state logic: period counter, shadows, segment/echo counters.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q + 32'd1;
    seg_d   = seg_q;
    ecnt_d  = ecnt_q;
    per_d   = per_q;
    p1_d    = p1_q;
    del_d   = del_q;
    p2_d    = p2_q;
    cp_d    = cp_q;
    pbl_d   = pbl_q;
    bl_d    = bl_q;
    nxt_s   = '0;
    if (boundary_s) begin
      pcnt_d = 32'd0;
      seg_d  = 17'd0;
      ecnt_d = 8'd0;
      if (enable) begin
        per_d = per;
        p1_d  = p1wid;
        del_d = del;
        p2_d  = p2wid;
        cp_d  = (cp == 8'd0) ? 8'd1 : cp;
        pbl_d = p_bl;
        bl_d  = bl;
        if (p1wid != 16'd0) begin
          state_d = S_P1;
        end else begin
          nxt_s   = enter_d1(del, p2wid, cp_d);
          state_d = nxt_s.st;
          ecnt_d  = nxt_s.ec;
        end
      end else begin
        state_d = S_IDLE;
      end
    end else if (seg_end_s) begin
      seg_d = 17'd0;
      case (state_q)
        S_P1:    nxt_s = enter_d1(del_q, p2_q, cp_q);
        S_D1:    nxt_s = enter_p2(del_q, p2_q, cp_q, ecnt_q);
        S_P2:    nxt_s = after_p2(del_q, cp_q, ecnt_q);
        S_GAP:   nxt_s = enter_p2(del_q, p2_q, cp_q, ecnt_q);
        default: begin
          nxt_s.st = state_q;
          nxt_s.ec = ecnt_q;
        end
      endcase
      state_d = nxt_s.st;
      ecnt_d  = nxt_s.ec;
    end else if (state_q != S_TAIL) begin
      seg_d = seg_q + 17'd1;
    end else begin
      seg_d = seg_q;
    end
  end

  // Output logic; the blanking tail reloads on every pulse fall so tails merge.
  always_comb begin
    pulse_d = (state_d == S_P1) || (state_d == S_P2);
    busy_d  = (state_d != S_IDLE);
    sync_d  = boundary_s && enable;
    if (state_d == S_IDLE) begin
      tail_d = 8'd0;
    end else if (pulse && !pulse_d) begin
      tail_d = pbl_d;
    end else if (tail_q != 8'd0) begin
      tail_d = tail_q - 8'd1;
    end else begin
      tail_d = tail_q;
    end
    block_d = busy_d && bl_d && (pulse_d || (tail_d != 8'd0));
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pcnt_q    <= 32'd0;
      seg_q     <= 17'd0;
      ecnt_q    <= 8'd0;
      per_q     <= 32'(DEF_PER);
      p1_q      <= 16'(DEF_P1);
      del_q     <= 16'(DEF_DEL);
      p2_q      <= 16'(DEF_P2);
      cp_q      <= 8'(DEF_CP);
      pbl_q     <= 8'(DEF_BL);
      bl_q      <= 1'b0;
      tail_q    <= 8'd0;
      pulse     <= 1'b0;
      block_out <= 1'b0;
      sync      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      seg_q     <= seg_d;
      ecnt_q    <= ecnt_d;
      per_q     <= per_d;
      p1_q      <= p1_d;
      del_q     <= del_d;
      p2_q      <= p2_d;
      cp_q      <= cp_d;
      pbl_q     <= pbl_d;
      bl_q      <= bl_d;
      tail_q    <= tail_d;
      pulse     <= pulse_d;
      block_out <= block_d;
      sync      <= sync_d;
      busy      <= busy_d;
    end
  end

endmodule
